// File: rtl/t03_mem_responder_if.sv
// Request/response bus between a CPU request unit (master) and the memory responder (slave).
// Requests are level-held until ack; ack and error are single-cycle pulses.
interface t03_mem_responder_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [3:0]  select;
  logic [31:0] readData;
  logic        ack;
  logic        error;
  logic        busy;

  modport master (
    output read, write, address, writeData, select,
    input  readData, ack, error, busy
  );

  modport slave (
    input  read, write, address, writeData, select,
    output readData, ack, error, busy
  );
endinterface

// File: rtl/t03_mem_responder.sv
// Word-addressed memory responder: captures a held read/write request, waits WAIT_STATES
// cycles, then completes it with a one-cycle ack and registered read data.
//
// state      | meaning
// ST_IDLE    | no request in flight; a high read/write is captured here
// ST_WAIT    | request latched, counting wait states; dropping the request aborts it
// ST_RESPOND | single ack cycle; the access was performed on the edge entering it
module t03_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  t03_mem_responder_if.slave bus
);
  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESPOND
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        op_write_q;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  sel_q;

  logic [31:0] read_data_q;
  logic        ack_q;
  logic        error_q;
  logic        busy_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          req;
  logic          cur_write;
  logic [31:2]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_sel;
  logic          go_respond;
  logic          in_range;
  logic [AW-1:0] word_idx;

  // With zero wait states the access happens on the capture edge, so it must
  // use the live bus inputs rather than the (not yet loaded) latched copies.
  always_comb begin
    req        = bus.read | bus.write;
    cur_write  = op_write_q;
    cur_addr   = addr_q;
    cur_wdata  = wdata_q;
    cur_sel    = sel_q;
    if (state == ST_IDLE) begin
      cur_write = bus.write;
      cur_addr  = bus.address[31:2];
      cur_wdata = bus.writeData;
      cur_sel   = bus.select;
    end
    go_respond = ((state == ST_IDLE) && req && (WAIT_INIT == 4'd0)) ||
                 ((state == ST_WAIT) && req && (cnt == 4'd1));
    // BASE_ADDR is aligned to the memory size, so range membership is a tag compare.
    in_range   = (cur_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    word_idx   = cur_addr[AW+1:2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      op_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      sel_q       <= 4'h0;
      read_data_q <= 32'h0;
      ack_q       <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ack_q   <= go_respond;
      error_q <= go_respond && !in_range;
      if (go_respond) begin
        if (!in_range) begin
          read_data_q <= 32'h0;
        end else if (!cur_write) begin
          read_data_q <= mem[word_idx];
        end
      end

      case (state)
        ST_IDLE: begin
          if (req) begin
            op_write_q <= bus.write;
            addr_q     <= bus.address[31:2];
            wdata_q    <= bus.writeData;
            sel_q      <= bus.select;
            cnt        <= WAIT_INIT;
            busy_q     <= 1'b1;
            if (WAIT_INIT == 4'd0) begin
              state <= ST_RESPOND;
            end else begin
              state <= ST_WAIT;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            busy_q <= 1'b0;
          end else begin
            cnt    <= cnt - 4'd1;
            busy_q <= 1'b1;
            if (cnt == 4'd1) begin
              state <= ST_RESPOND;
            end
          end
        end
        ST_RESPOND: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Memory contents survive reset; only a completing in-range write touches them.
  always_ff @(posedge clk) begin
    if (!rst && go_respond && cur_write && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel[b]) begin
          mem[word_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.readData = read_data_q;
  assign bus.ack      = ack_q;
  assign bus.error    = error_q;
  assign bus.busy     = busy_q;
endmodule
